cfo_test_seq: RTL and testbench

//  Sequences the CFO stimulus generator through its four fixed patterns (SEL 0..3) and checks the
//  CFO estimator's freq_word against the expected value for each pattern. Sits between the stimulus

---
 rtl/cfo_test_seq_if.sv | 13 +
 rtl/cfo_test_seq.sv | 186 ++++++++++++++++++
 tb/tb_cfo_test_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cfo_test_seq_if.sv
// CFO self-test bus: pattern select, symbol strobe and reset toward the
// stimulus/estimator pair, frequency word and valid coming back.
// master = sequencer side, slave = stimulus/estimator side.
interface cfo_test_seq_if;
    logic [1:0]  sel;
    logic        val;
    logic        dut_rst;
    logic [31:0] freq_word;
    logic        freq_val;

    modport master (output sel, val, dut_rst, input freq_word, freq_val);
    modport slave  (input sel, val, dut_rst, output freq_word, freq_val);
endinterface

// File: rtl/cfo_test_seq.sv
// CFO estimator self-test sequencer.
// Steps patterns 0..NUM_SEL-1: resets the stimulus/estimator, issues SYM_CNT
// strobes, waits for freq_val (bounded by TIMEOUT) and checks the word against
// the pattern's expected value within +/-TOL.
// Optional feature macro CFO_SEQ_CAPTURE_EN: capture per-pattern words on meas_o.
module cfo_test_seq #(
    parameter int unsigned NUM_SEL = 4,
    parameter int unsigned SYM_CNT = 256,
    parameter int unsigned VAL_DIV = 4,
    parameter int unsigned RST_CYC = 4,
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [31:0] TOL     = 32'h0010
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    cfo_test_seq_if.master        bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [3:0]            fail_mask_o,
    output logic [127:0]          meas_o
);
    localparam int unsigned CMAX = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned PW   = $clog2(VAL_DIV + 1);
    localparam int unsigned SW   = $clog2(SYM_CNT + 1);

    localparam logic [CW-1:0]     RST_LAST = CW'(RST_CYC - 1);
    localparam logic [CW-1:0]     TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0]     PH_LAST  = PW'(VAL_DIV - 1);
    localparam logic [SW-1:0]     SYM_LAST = SW'(SYM_CNT - 1);
    localparam logic [1:0]        SEL_LAST = 2'(NUM_SEL - 1);
    localparam logic signed [31:0] TOL_S   = TOL;
    localparam logic [31:0]       TO_MARK  = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        S_IDLE, S_DRST, S_RUN, S_WAIT, S_CHECK, S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      sel;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   phase;
    logic [SW-1:0]   pulses;
    logic [31:0]     word_q;
    logic            to_q;
    logic [3:0]      fail_mask;
    logic            pass_q;

    logic            strobe, dut_rst_c, busy_c, done_c;
    logic [31:0]     exp_word;
    logic signed [31:0] diff_s;
    logic            chk_fail;
    logic [3:0]      fail_bit, mask_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and per-state outputs
    always_comb begin
        state_nxt = state;
        strobe    = 1'b0;
        dut_rst_c = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            S_IDLE:  if (start_i) state_nxt = S_DRST;
            S_DRST: begin
                dut_rst_c = 1'b1;
                busy_c    = 1'b1;
                if (cnt == RST_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy_c = 1'b1;
                strobe = (phase == '0);
                if (strobe && pulses == SYM_LAST) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy_c = 1'b1;
                strobe = (phase == '0);
                if (bus.freq_val || cnt == TO_LAST) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                busy_c    = 1'b1;
                state_nxt = (sel == SEL_LAST) ? S_DONE : S_DRST;
            end
            S_DONE: begin
                done_c    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Tolerance check of the latched word against the pattern's expected value
    always_comb begin
        case (sel)
            2'd2:    exp_word = 32'h2000_0000;
            2'd3:    exp_word = 32'hE000_0000;
            default: exp_word = 32'h0000_0000;
        endcase
        diff_s   = word_q - exp_word;
        chk_fail = to_q || (diff_s < -TOL_S) || (diff_s > TOL_S);
        fail_bit = '0;
        fail_bit[sel] = chk_fail;
        mask_nxt = fail_mask | fail_bit;
    end

    // Counters, word latch and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sel       <= '0;
            cnt       <= '0;
            phase     <= '0;
            pulses    <= '0;
            word_q    <= '0;
            to_q      <= 1'b0;
            fail_mask <= '0;
            pass_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    sel       <= '0;
                    cnt       <= '0;
                    fail_mask <= '0;
                    pass_q    <= 1'b0;
                end
                S_DRST: begin
                    phase  <= '0;
                    pulses <= '0;
                    to_q   <= 1'b0;
                    cnt    <= (cnt == RST_LAST) ? '0 : cnt + 1'b1;
                end
                S_RUN: begin
                    phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
                    if (strobe) pulses <= pulses + 1'b1;
                end
                S_WAIT: begin
                    phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
                    cnt   <= cnt + 1'b1;
                    if (bus.freq_val) begin
                        word_q <= bus.freq_word;
                    end else if (cnt == TO_LAST) begin
                        word_q <= TO_MARK;
                        to_q   <= 1'b1;
                    end
                end
                S_CHECK: begin
                    cnt       <= '0;
                    fail_mask <= mask_nxt;
                    // pass is settled here so it is already valid in the done cycle
                    if (sel == SEL_LAST) pass_q <= (mask_nxt == '0);
                    else                 sel    <= sel + 2'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef CFO_SEQ_CAPTURE_EN
    logic [127:0] meas_q;

    // Per-pattern capture of the checked word, cleared by an accepted start
    always_ff @(posedge clk) begin
        if (rst)                              meas_q <= '0;
        else if (state == S_IDLE && start_i)  meas_q <= '0;
        else if (state == S_CHECK)            meas_q[{sel, 5'd0} +: 32] <= word_q;
    end

    assign meas_o = meas_q;
`else
    assign meas_o = '0;
`endif

    assign bus.sel     = sel;
    assign bus.val     = strobe;
    assign bus.dut_rst = dut_rst_c;
    assign busy_o      = busy_c;
    assign done_o      = done_c;
    assign pass_o      = pass_q;
    assign fail_mask_o = fail_mask;
endmodule

// File: tb/tb_cfo_test_seq.sv
// Self-checking bench for cfo_test_seq: table vectors, randomized runs against
// a spec-level estimator/scoreboard model, mid-run reset, and a NUM_SEL=2 build.
`timescale 1ns/1ps
module tb_cfo_test_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [31:0] fw;
    logic        fv;
    int          which;
    int          n_chk = 0, n_err = 0;
    int          p_num, p_sym, p_div, p_rcyc, p_tmo;

    cfo_test_seq_if ifa ();
    cfo_test_seq_if ifb ();

    logic         a_busy, a_done, a_pass, b_busy, b_done, b_pass;
    logic [3:0]   a_mask, b_mask;
    logic [127:0] a_meas, b_meas;

    assign ifa.freq_word = fw;
    assign ifb.freq_word = fw;
    assign ifa.freq_val  = (which == 0) ? fv : 1'b0;
    assign ifb.freq_val  = (which == 1) ? fv : 1'b0;

    cfo_test_seq dut_a (
        .clk(clk), .rst(rst), .start_i(start & (which == 0)), .bus(ifa),
        .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass),
        .fail_mask_o(a_mask), .meas_o(a_meas)
    );

    cfo_test_seq #(.NUM_SEL(2), .SYM_CNT(8), .VAL_DIV(1), .RST_CYC(2), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .start_i(start & (which == 1)), .bus(ifb),
        .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass),
        .fail_mask_o(b_mask), .meas_o(b_meas)
    );

    logic [1:0]   c_sel;
    logic         c_val, c_drst, c_busy, c_done, c_pass;
    logic [3:0]   c_mask;
    logic [127:0] c_meas;
    assign c_sel  = (which == 0) ? ifa.sel     : ifb.sel;
    assign c_val  = (which == 0) ? ifa.val     : ifb.val;
    assign c_drst = (which == 0) ? ifa.dut_rst : ifb.dut_rst;
    assign c_busy = (which == 0) ? a_busy : b_busy;
    assign c_done = (which == 0) ? a_done : b_done;
    assign c_pass = (which == 0) ? a_pass : b_pass;
    assign c_mask = (which == 0) ? a_mask : b_mask;
    assign c_meas = (which == 0) ? a_meas : b_meas;

    // estimator response per pattern
    logic [31:0] resp_word [4];
    bit          resp_on   [4];
    int          resp_dly  [4];

    typedef struct packed {
        logic [3:0][31:0] w;
        logic [3:0]       on;
        logic [3:0][4:0]  dly;
        logic [3:0]       mask;
        logic             pass;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] expw(input int s);
        case (s)
            2:       return 32'h2000_0000;
            3:       return 32'hE000_0000;
            default: return 32'h0;
        endcase
    endfunction

    // reference: fail if no response, else signed distance beyond 16
    function automatic bit ref_fail(input int s, input bit on, input logic [31:0] w);
        logic [31:0] d;
        longint sd;
        if (!on) return 1'b1;
        d  = w - expw(s);
        sd = longint'($signed(d));
        return !(sd >= -16 && sd <= 16);
    endfunction

    task automatic use_dut(input int w);
        which = w;
        if (w == 0) begin p_num = 4; p_sym = 256; p_div = 4; p_rcyc = 4; p_tmo = 1024; end
        else        begin p_num = 2; p_sym = 8;   p_div = 1; p_rcyc = 2; p_tmo = 16;   end
    endtask

    task automatic run_seq(input logic [3:0] emask, input bit epass, input bit inj);
        int pred, done_cnt, done_at, pulses, wcyc;
        int rcnt [4];
        bit in_wait;
        logic [127:0] emeas;
        emeas = '0;
        pred  = 1;
        for (int s = 0; s < p_num; s++) begin
            emeas[32*s +: 32] = resp_on[s] ? resp_word[s] : 32'hDEAD_BEEF;
            pred += p_rcyc + (p_sym - 1) * p_div + 1 + (resp_on[s] ? resp_dly[s] + 1 : p_tmo) + 1;
        end
`ifndef CFO_SEQ_CAPTURE_EN
        emeas = '0;
`endif
        for (int s = 0; s < 4; s++) rcnt[s] = 0;
        done_cnt = 0; done_at = -1; pulses = 0; wcyc = 0; in_wait = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= pred + 64; cyc++) begin
            @(negedge clk);
            start = inj && c_busy && ($urandom_range(0, 15) == 0);
            if (cyc == 1) begin
                check("start_sel0", c_sel, 0);
                check("start_mask_clr", c_mask, 0);
                check("start_pass_clr", c_pass, 0);
                check("start_busy", c_busy, 1);
            end
            if (c_drst) begin rcnt[c_sel]++; pulses = 0; in_wait = 0; end
            if (c_done) begin
                done_cnt++; done_at = cyc;
                check("mask_at_done", c_mask, emask);
                check("pass_at_done", c_pass, epass);
            end
            if (in_wait) begin
                wcyc++;
                fw = resp_word[c_sel];
                fv = resp_on[c_sel] && (wcyc == resp_dly[c_sel]);
                if (fv) in_wait = 0;
            end else begin
                fw = $urandom;
                fv = ($urandom_range(0, 3) == 0);
            end
            if (c_val && pulses < p_sym) begin
                pulses++;
                if (pulses == p_sym) begin in_wait = 1; wcyc = -1; end
            end
            if (done_cnt != 0 && cyc >= done_at + 8) break;
        end
        start = 1'b0; fv = 1'b0;
        check("done_count", done_cnt, 1);
        check("done_cycle", done_at, pred);
        for (int s = 0; s < 4; s++) check("dut_rst_cycles", rcnt[s], (s < p_num) ? p_rcyc : 0);
        check("mask_hold", c_mask, emask);
        check("pass_hold", c_pass, epass);
        check("idle_busy", c_busy, 0);
        check("meas", c_meas, emeas);
    endtask

    task automatic load_vec(input int i);
        for (int s = 0; s < 4; s++) begin
            resp_word[s] = vecs[i].w[s];
            resp_on[s]   = vecs[i].on[s];
            resp_dly[s]  = int'(vecs[i].dly[s]);
        end
    endtask

    task automatic rst_mid();
        bit found;
        int dn;
        use_dut(0);
        found = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 8000; k++) begin
            @(negedge clk);
            start = 1'b0; fv = 1'b0;
            if (c_sel == 2'd1 && c_val) begin found = 1; break; end
        end
        check("rst_reach_sel1_run", found, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_sel", c_sel, 0);
        check("rst_val", c_val, 0);
        check("rst_dutrst", c_drst, 0);
        check("rst_busy", c_busy, 0);
        check("rst_done", c_done, 0);
        check("rst_pass", c_pass, 0);
        check("rst_mask", c_mask, 0);
        check("rst_meas", c_meas, 0);
        dn = 0;
        repeat (40) begin @(negedge clk); if (c_done) dn++; end
        check("rst_no_done", dn, 0);
    endtask

    initial begin
        // w/on/dly listed sel3..sel0
        vecs[0] = '{w: {32'hE000_0000, 32'h2000_0000, 32'h0, 32'h0}, on: 4'b1111,
                    dly: {5'd1, 5'd7, 5'd3, 5'd0}, mask: 4'b0000, pass: 1'b1};
        vecs[1] = '{w: {32'hE000_0000, 32'h2000_0020, 32'h0, 32'h0}, on: 4'b1111,
                    dly: {5'd2, 5'd0, 5'd5, 5'd9}, mask: 4'b0100, pass: 1'b0};
        vecs[2] = '{w: {32'hE000_0000, 32'h2000_0000, 32'h0, 32'hFFFF_FFF8}, on: 4'b1111,
                    dly: {5'd0, 5'd1, 5'd2, 5'd3}, mask: 4'b0000, pass: 1'b1};
        vecs[3] = '{w: {32'hE000_0000, 32'h2000_0000, 32'h0, 32'h0}, on: 4'b0111,
                    dly: {5'd0, 5'd4, 5'd0, 5'd6}, mask: 4'b1000, pass: 1'b0};
        vecs[4] = '{w: {32'hE000_000F, 32'h1FFF_FFF0, 32'h0000_0010, 32'hFFFF_FFF0}, on: 4'b1111,
                    dly: {5'd3, 5'd3, 5'd3, 5'd3}, mask: 4'b0000, pass: 1'b1};
        vecs[5] = '{w: {32'hDFFF_FFEF, 32'h2000_0000, 32'h0, 32'h0000_0011}, on: 4'b1111,
                    dly: {5'd8, 5'd0, 5'd1, 5'd2}, mask: 4'b1001, pass: 1'b0};
        vecs[6] = '{w: {32'hE000_0000, 32'hA000_0000, 32'h8000_0000, 32'h0}, on: 4'b1111,
                    dly: {5'd0, 5'd2, 5'd11, 5'd0}, mask: 4'b0110, pass: 1'b0};

        rst = 1'b1; start = 1'b0; fv = 1'b0; fw = '0;
        use_dut(0);
        repeat (3) @(negedge clk);
        check("reset_busy_a", a_busy, 0);
        check("reset_done_a", a_done, 0);
        check("reset_pass_a", a_pass, 0);
        check("reset_mask_a", a_mask, 0);
        check("reset_meas_a", a_meas, 0);
        check("reset_bus_a", {ifa.sel, ifa.val, ifa.dut_rst}, 0);
        check("reset_bus_b", {ifb.sel, ifb.val, ifb.dut_rst, b_busy, b_pass, b_mask}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            load_vec(i);
            run_seq(vecs[i].mask, vecs[i].pass, (i % 2) == 1);
        end

        for (int r = 0; r < 3; r++) begin
            logic [3:0] em;
            em = '0;
            for (int s = 0; s < 4; s++) begin
                resp_on[s]   = 1'b1;
                resp_dly[s]  = $urandom_range(0, 12);
                if ($urandom_range(0, 4) == 0) resp_word[s] = $urandom;
                else resp_word[s] = expw(s) + 32'($urandom_range(0, 40)) - 32'd20;
                em[s] = ref_fail(s, resp_on[s], resp_word[s]);
            end
            run_seq(em, em == 4'b0000, 1'b1);
        end

        rst_mid();
        load_vec(0);
        run_seq(4'b0000, 1'b1, 1'b0);

        use_dut(1);
        resp_word[0] = 32'h0000_0005; resp_on[0] = 1'b1; resp_dly[0] = 2;
        resp_word[1] = 32'h0;         resp_on[1] = 1'b0; resp_dly[1] = 0;
        resp_word[2] = 32'h1234_5678; resp_on[2] = 1'b1; resp_dly[2] = 0;
        resp_word[3] = 32'h1234_5678; resp_on[3] = 1'b1; resp_dly[3] = 0;
        run_seq(4'b0010, 1'b0, 1'b1);
        resp_on[1] = 1'b1; resp_word[1] = 32'hFFFF_FFF0; resp_dly[1] = 15;
        run_seq(4'b0000, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
